// File: rtl/mimasuo_pkg.sv
// Shared definitions for the mimasuo code lock: state encodings and a counter-width helper.
package mimasuo_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENTRY    = 3'd1;
    localparam logic [2:0] ST_UNLOCKED = 3'd2;
    localparam logic [2:0] ST_PROG     = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mimasuo_btn_edge.sv
// Button input registers and rising-edge press detection for the two code buttons.
module mimasuo_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button0,
    input  logic i_button1,
    output logic o_press0,
    output logic o_press1,
    output logic o_dual
);

    logic r_btn0;
    logic r_btn1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn0 <= 1'b0;
            r_btn1 <= 1'b0;
        end else begin
            r_btn0 <= i_button0;
            r_btn1 <= i_button1;
        end
    end

    // Presses are combinational so the FSM acts on the very edge that samples the rise.
    assign o_press0 = i_button0 & ~r_btn0;
    assign o_press1 = i_button1 & ~r_btn1;
    assign o_dual   = o_press0 & o_press1;

endmodule

// File: rtl/mimasuo_logic_param.sv
// Parametrised two-button code lock with failure lockout, timed unlock, entry timeout
// and code reprogramming while unlocked.
module mimasuo_logic_param
    import mimasuo_pkg::*;
#(
    parameter int unsigned         CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1011,
    parameter int unsigned         MAX_FAIL       = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 16,
    parameter int unsigned         UNLOCK_CYCLES  = 8,
    parameter int unsigned         IDLE_TIMEOUT   = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           button0,
    input  logic                           button1,
    input  logic                           prog_en,
    output logic                           UNLOCK,
    output logic                           locked_out,
    output logic                           prog_active,
    output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

    localparam int unsigned FW      = $clog2(MAX_FAIL + 1);
    localparam int unsigned BW      = cnt_width(CODE_LEN);
    localparam int unsigned TMR_MAX =
        (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
            ((LOCKOUT_CYCLES > IDLE_TIMEOUT) ? LOCKOUT_CYCLES : IDLE_TIMEOUT) :
            ((UNLOCK_CYCLES > IDLE_TIMEOUT) ? UNLOCK_CYCLES : IDLE_TIMEOUT);
    localparam int unsigned TW      = cnt_width(TMR_MAX);

    logic                w_press0;
    logic                w_press1;
    logic                w_dual;
    logic                w_valid;
    logic                w_bit;
    logic                w_done;
    logic                w_timeout;
    logic [CODE_LEN-1:0] w_cand;

    logic [2:0]          r_state;
    logic [2:0]          w_state_d;
    logic [CODE_LEN-1:0] r_shift;
    logic [CODE_LEN-1:0] w_shift_d;
    logic [BW-1:0]       r_bit_cnt;
    logic [BW-1:0]       w_bit_cnt_d;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer_d;
    logic [FW-1:0]       r_fail;
    logic [FW-1:0]       w_fail_d;
    logic [CODE_LEN-1:0] r_code;
    logic [CODE_LEN-1:0] w_code_d;
    logic                r_unlock;
    logic                r_locked;
    logic                r_prog;
    logic                w_unlock_d;
    logic                w_locked_d;
    logic                w_prog_d;

    mimasuo_btn_edge u_btn_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_button0 (button0),
        .i_button1 (button1),
        .o_press0  (w_press0),
        .o_press1  (w_press1),
        .o_dual    (w_dual)
    );

    assign w_valid   = w_press0 ^ w_press1;
    assign w_bit     = w_press1;
    assign w_cand    = CODE_LEN'({r_shift, w_bit});
    assign w_done    = (r_bit_cnt == BW'(CODE_LEN - 1));
    assign w_timeout = (r_timer == TW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
            r_fail    <= '0;
            r_code    <= DEFAULT_CODE;
            r_unlock  <= 1'b0;
            r_locked  <= 1'b0;
            r_prog    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_timer   <= w_timer_d;
            r_fail    <= w_fail_d;
            r_code    <= w_code_d;
            r_unlock  <= w_unlock_d;
            r_locked  <= w_locked_d;
            r_prog    <= w_prog_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_fail_d    = r_fail;
        w_code_d    = r_code;
        case (r_state)
            // IDLE shares the ENTRY path: a dual press or timeout there is a no-op.
            ST_IDLE, ST_ENTRY: begin
                if (w_valid) begin
                    if (w_done) begin
                        w_shift_d   = '0;
                        w_bit_cnt_d = '0;
                        if (w_cand == r_code) begin
                            w_state_d = ST_UNLOCKED;
                            w_fail_d  = '0;
                        end else begin
                            w_fail_d  = (r_fail == FW'(MAX_FAIL)) ? r_fail : r_fail + 1'b1;
                            w_state_d = (w_fail_d == FW'(MAX_FAIL)) ? ST_LOCKOUT : ST_IDLE;
                        end
                    end else begin
                        w_shift_d   = w_cand;
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                        w_state_d   = ST_ENTRY;
                    end
                end else if (w_dual || w_timeout) begin
                    w_shift_d   = '0;
                    w_bit_cnt_d = '0;
                    w_state_d   = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (w_valid) begin
                    if (w_done) begin
                        w_code_d    = w_cand;
                        w_shift_d   = '0;
                        w_bit_cnt_d = '0;
                        w_state_d   = ST_IDLE;
                    end else begin
                        w_shift_d   = w_cand;
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                    end
                end else if (w_dual || w_timeout) begin
                    w_shift_d   = '0;
                    w_bit_cnt_d = '0;
                    w_state_d   = ST_IDLE;
                end
            end
            ST_UNLOCKED: begin
                if (prog_en) begin
                    w_state_d = ST_PROG;
                end else if (r_timer == TW'(UNLOCK_CYCLES - 1)) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
                    w_fail_d  = '0;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d   = ST_IDLE;
                w_shift_d   = '0;
                w_bit_cnt_d = '0;
            end
        endcase

        // Presses only restart the timer where they are accepted as code bits.
        if ((w_state_d != r_state) || (r_state == ST_IDLE) ||
            (w_valid && ((r_state == ST_ENTRY) || (r_state == ST_PROG)))) begin
            w_timer_d = '0;
        end else begin
            w_timer_d = r_timer + 1'b1;
        end
    end

    always_comb begin
        w_unlock_d = (w_state_d == ST_UNLOCKED);
        w_locked_d = (w_state_d == ST_LOCKOUT);
        w_prog_d   = (w_state_d == ST_PROG);
    end

    assign UNLOCK      = r_unlock;
    assign locked_out  = r_locked;
    assign prog_active = r_prog;
    assign fail_cnt    = r_fail;

endmodule

// File: tb/tb_mimasuo_logic_param.sv
// Self-checking bench for mimasuo_logic_param: constant vector table, directed sequences
// and randomized traffic against a behavioural model of the lock.
module tb_mimasuo_logic_param;

    localparam int CODE_LEN       = 4;
    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int UNLOCK_CYCLES  = 8;
    localparam int IDLE_TIMEOUT   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button0 = 1'b0;
    logic       button1 = 1'b0;
    logic       prog_en = 1'b0;
    logic       UNLOCK;
    logic       locked_out;
    logic       prog_active;
    logic [1:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    mimasuo_logic_param #(
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (4'b1011),
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .IDLE_TIMEOUT   (IDLE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button0     (button0),
        .button1     (button1),
        .prog_en     (prog_en),
        .UNLOCK      (UNLOCK),
        .locked_out  (locked_out),
        .prog_active (prog_active),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining-cycle countdowns and a queue of entered bits.
    int   m_unlock_left;
    int   m_lock_left;
    bit   m_prog;
    int   m_quiet;
    int   m_fail;
    int   m_code;
    bit   m_prev0;
    bit   m_prev1;
    bit   m_bits[$];

    task automatic model_reset();
        m_unlock_left = 0;
        m_lock_left   = 0;
        m_prog        = 1'b0;
        m_quiet       = 0;
        m_fail        = 0;
        m_code        = 'b1011;
        m_prev0       = 1'b0;
        m_prev1       = 1'b0;
        m_bits.delete();
    endtask

    task automatic model_abort();
        m_bits.delete();
        m_prog  = 1'b0;
        m_quiet = 0;
    endtask

    task automatic model_step(input bit b0, input bit b1, input bit pe);
        bit p0, p1, collecting;
        int val;
        p0 = b0 && !m_prev0;
        p1 = b1 && !m_prev1;
        m_prev0 = b0;
        m_prev1 = b1;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fail = 0;
        end else if (m_unlock_left > 0) begin
            if (pe) begin
                m_unlock_left = 0;
                m_prog = 1'b1;
                m_bits.delete();
                m_quiet = 0;
            end else begin
                m_unlock_left--;
            end
        end else begin
            collecting = m_prog || (m_bits.size() > 0);
            if (p0 != p1) begin
                m_bits.push_back(p1);
                m_quiet = 0;
                if (m_bits.size() == CODE_LEN) begin
                    val = 0;
                    foreach (m_bits[i]) val = (val << 1) | int'(m_bits[i]);
                    m_bits.delete();
                    if (m_prog) begin
                        m_code = val;
                        m_prog = 1'b0;
                    end else if (val == m_code) begin
                        m_unlock_left = UNLOCK_CYCLES;
                        m_fail = 0;
                    end else begin
                        m_fail = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
                        if (m_fail == MAX_FAIL) m_lock_left = LOCKOUT_CYCLES;
                    end
                end
            end else if (collecting) begin
                if (p0 && p1) begin
                    model_abort();
                end else begin
                    m_quiet++;
                    if (m_quiet == IDLE_TIMEOUT) model_abort();
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("unlock", 32'(UNLOCK), 32'(m_unlock_left > 0));
        check("locked_out", 32'(locked_out), 32'(m_lock_left > 0));
        check("prog_active", 32'(prog_active), 32'(m_prog));
        check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    endtask

    task automatic cycle(input bit b0, input bit b1, input bit pe);
        button0 = b0;
        button1 = b1;
        prog_en = pe;
        @(posedge clk);
        model_step(b0, b1, pe);
        #1;
        check_model();
    endtask

    task automatic press(input bit b);
        cycle(!b, b, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [3:0] code);
        for (int i = CODE_LEN - 1; i >= 0; i--) press(code[i]);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        button0 = 1'b0;
        button1 = 1'b0;
        prog_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, UNLOCK, locked_out, prog_active, |fail_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit       b0;
        bit       b1;
        bit       pe;
        bit       unlock;
        bit       locked;
        bit       prog;
        int       fail;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit b0, bit b1, bit pe, bit u, bit l, bit p, int f);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.pe = pe;
        v.unlock = u; v.locked = l; v.prog = p; v.fail = f;
        return v;
    endfunction

    initial begin
        int  k;
        int  r;
        bit  seen;
        logic [3:0] rc;

        model_reset();

        // Correct code 1011 then eight-cycle unlock window.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // Wrong code 1111.
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        // Held button counts once, then dual press clears the entry.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        // 0,1,1 after the cleared entry: a held bit would have made this a wrong code.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));

        do_reset();
        foreach (vecs[i]) begin
            button0 = vecs[i].b0;
            button1 = vecs[i].b1;
            prog_en = vecs[i].pe;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_unlock", i), 32'(UNLOCK), 32'(vecs[i].unlock));
            check($sformatf("vec%0d_locked", i), 32'(locked_out), 32'(vecs[i].locked));
            check($sformatf("vec%0d_prog", i), 32'(prog_active), 32'(vecs[i].prog));
            check($sformatf("vec%0d_fail", i), 32'(fail_cnt), 32'(vecs[i].fail));
        end

        // Three wrong codes -> lockout; correct code ignored during it.
        do_reset();
        for (int i = 0; i < 3; i++) enter_code(4'b1111);
        check("lockout_entered", 32'(locked_out), 32'd1);
        enter_code(4'b1011);
        check("lockout_no_unlock", 32'(UNLOCK), 32'd0);
        k = 0;
        while (locked_out && k < 40) begin
            cycle(0, 0, 0);
            k++;
        end
        check("lockout_exit", 32'(locked_out), 32'd0);
        check("lockout_fail_clr", 32'(fail_cnt), 32'd0);
        enter_code(4'b1011);
        check("unlock_after_lockout", 32'(UNLOCK), 32'd1);

        // Timeout after two bits.
        do_reset();
        press(1);
        press(0);
        repeat (IDLE_TIMEOUT) cycle(0, 0, 0);
        enter_code(4'b1011);
        check("timeout_then_unlock", 32'(UNLOCK), 32'd1);
        check("timeout_no_fail", 32'(fail_cnt), 32'd0);

        // Reprogram to 0110.
        do_reset();
        enter_code(4'b1011);
        cycle(0, 0, 1);
        check("prog_active", 32'(prog_active), 32'd1);
        check("prog_unlock_fell", 32'(UNLOCK), 32'd0);
        enter_code(4'b0110);
        check("prog_done", 32'(prog_active), 32'd0);
        enter_code(4'b1011);
        check("old_code_fails", 32'(fail_cnt), 32'd1);
        enter_code(4'b0110);
        check("new_code_unlocks", 32'(UNLOCK), 32'd1);

        // Async reset mid-PROG after two bits restores the default code.
        repeat (UNLOCK_CYCLES + 2) cycle(0, 0, 0);
        enter_code(4'b0110);
        cycle(0, 0, 1);
        press(1);
        press(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_prog", 32'(prog_active), 32'd0);
        check("async_rst_all", {28'd0, UNLOCK, locked_out, prog_active, |fail_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        enter_code(4'b0110);
        check("rst_code_restored", 32'(fail_cnt), 32'd1);
        enter_code(4'b1011);
        check("rst_default_unlocks", 32'(UNLOCK), 32'd1);

        // Randomized traffic, occasionally typing the currently valid code.
        do_reset();
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                rc = 4'(m_code);
                enter_code(rc);
                if (UNLOCK) seen = 1'b1;
            end else begin
                r = $urandom_range(0, 9);
                cycle(r == 8 || r == 9, r == 6 || r == 7 || r == 9,
                      $urandom_range(0, 3) == 0);
            end
        end
        check("random_saw_unlock", 32'(seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
